vga_timing_ctrl: RTL and testbench
==================================

Name: vga_timing_ctrl

Overview:
- VGA raster timing generator. It is the consumer/driver end of the pix_x/pix_y -> pix_data interface used by the picture-generator blocks.
- Runs free-running horizontal and vertical counters and produces hsync, vsync and an active-video strobe.
- Presents pix_x/pix_y one cycle early so a registered pattern source can return pix_data in time. Gates that data onto the rgb output for the downstream HDMI/TMDS encoder.
- Default timing is 640x480@60 Hz on a 25.2 MHz vga_clk.

Parameters:
- H_SYNC, 96, hsync pulse width in clocks
- H_BACK, 40, horizontal back porch
- H_LEFT, 8, left border
- H_VALID, 640, active pixels per line
- H_RIGHT, 8, right border
- H_FRONT, 8, horizontal front porch
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 25, vertical back porch
- V_TOP, 8, top border
- V_VALID, 480, active lines
- V_BOTTOM, 8, bottom border
- V_FRONT, 2, vertical front porch

Ports:
- vga_clk  in  1  pixel clock (already decided)
- sys_rst_n  in  1  asynchronous active-low reset (already decided)
- pix_data  in  16  RGB565 pixel returned by the pattern source, one cycle after pix_x/pix_y
- pix_x  out  10  requested column 0..H_VALID-1; 10'h3FF outside the request window
- pix_y  out  10  requested row 0..V_VALID-1; 10'h3FF outside the request window
- hsync  out  1  horizontal sync, active high
- vsync  out  1  vertical sync, active high
- rgb_valid  out  1  active-video strobe
- rgb  out  16  pix_data when rgb_valid, else 16'h0000
- frame_start  out  1  one-cycle pulse at the first clock of each frame

Behaviour:
- Derived constants:
  - H_TOTAL = sum of all H_* = 800; V_TOTAL = sum of all V_* = 525.
  - HS = H_SYNC+H_BACK+H_LEFT = 144; HE = HS+H_VALID = 784.
  - VS = V_SYNC+V_BACK+V_TOP = 35; VE = VS+V_VALID = 515.
- cnt_h (10 bit, registered):
  - Reset 0; increments every clock.
  - At H_TOTAL-1 wraps to 0.
- cnt_v (10 bit, registered):
  - Reset 0; increments only when cnt_h == H_TOTAL-1.
  - At that point, if cnt_v == V_TOTAL-1, wraps to 0.
- Timing decodes (combinational from the counters):
  - hsync = (cnt_h <= H_SYNC-1).
  - vsync = (cnt_v <= V_SYNC-1).
  - rgb_valid = (HS <= cnt_h < HE) && (VS <= cnt_v < VE).
- Request window:
  - pix_req = (HS-1 <= cnt_h < HE-1) && (VS <= cnt_v < VE), i.e. rgb_valid advanced by exactly one clock.
  - Inside the window, pix_x = cnt_h-(HS-1) and pix_y = cnt_v-VS. Otherwise both are 10'h3FF.
  - Width rule: subtraction is 10-bit unsigned and only evaluated inside the window, so it never underflows.
- Latency: pix_x = N at clock t gives rgb_valid = 1 at t+1, with rgb = pix_data sampled at t+1. Fixed, single-cycle pixel-source contract.
- rgb = rgb_valid ? pix_data : 16'h0000. Combinational, no extra register.
- frame_start:
  - Registered. Set when (cnt_h == H_TOTAL-1 && cnt_v == V_TOTAL-1), so it is high for exactly the clock where both counters read 0.
  - No pulse for the first frame after reset.
- Reset values (while sys_rst_n = 0):
  - cnt_h = cnt_v = 0, so hsync = 1 and vsync = 1.
  - rgb_valid = 0, rgb = 0, pix_x = pix_y = 10'h3FF, frame_start = 0.
- Reset mid-frame: counters return to 0 immediately (asynchronous). Scanning restarts at the top-left sync region on the first clock after release; no partial-line recovery.
- Line wrap: at cnt_h = HE-1, pix_x returns to 3FF while rgb_valid stays high for its last pixel (639).
- Frame wrap: on the last line (cnt_v = V_TOTAL-1) no request is issued. The first request of a frame is at cnt_v = VS, cnt_h = HS-1.
- pix_data is don't-care whenever rgb_valid = 0; rgb must still read 0.

Decomposition:
- Package vga_timing_pkg:
  - 640x480@60 timing constants plus derived H_TOTAL/V_TOTAL/HS/HE/VS/VE.
  - Shared RGB565 colour constants (RED, GREEN, BLUE, BLACK, WHITE, GRAY, etc.) for pattern sources and benches.
- One sub-module vga_wrap_cnt (enable, terminal value, wrap flag out), instantiated for cnt_h (enable = 1) and cnt_v (enable = h wrap).

Test Plan:
- Reset hold 10 clocks, release -> hsync = 1, vsync = 1, pix_x = 3FF, rgb = 0, frame_start = 0 throughout reset. After release, cnt_h period is 800 clocks and hsync is high for clocks 0..95.
- Run one full frame -> 525 lines of 800 clocks. vsync is high for lines 0..1. frame_start pulses once, exactly 420000 clocks after the first (0,0).
- Line 35, cnt_h 143 -> pix_x = 0, pix_y = 0, rgb_valid = 0. At cnt_h 144: rgb_valid = 1. At cnt_h 782: pix_x = 639. At cnt_h 783: pix_x = 3FF, rgb_valid = 1. At cnt_h 784: rgb_valid = 0.
- Bench pixel source registers pix_data = {6'b0, pix_x} -> rgb equals the previous pix_x for all 640 pixels of line 35 and of line 514. On line 515, rgb = 0 with pix_data forced to FFFF.
- Attach a colour-bar source (RED at pix_x 0) -> first active rgb on each active line = 16'hF800. Blanking rgb = 0.
- Deassert-then-assert reset at line 200, cnt_h 400 -> outputs return to reset values asynchronously. After release, the first request (pix_x = 0, pix_y = 0) appears 35*800+143 clocks later.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 on a 25.2 MHz pixel clock) and
// RGB565 colour values used by the timing generator, pattern sources and benches.
package vga_timing_pkg;

  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 40;
  localparam int DEF_H_LEFT   = 8;
  localparam int DEF_H_VALID  = 640;
  localparam int DEF_H_RIGHT  = 8;
  localparam int DEF_H_FRONT  = 8;

  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 25;
  localparam int DEF_V_TOP    = 8;
  localparam int DEF_V_VALID  = 480;
  localparam int DEF_V_BOTTOM = 8;
  localparam int DEF_V_FRONT  = 2;

  localparam int DEF_H_TOTAL = DEF_H_SYNC + DEF_H_BACK + DEF_H_LEFT + DEF_H_VALID
                             + DEF_H_RIGHT + DEF_H_FRONT;
  localparam int DEF_V_TOTAL = DEF_V_SYNC + DEF_V_BACK + DEF_V_TOP + DEF_V_VALID
                             + DEF_V_BOTTOM + DEF_V_FRONT;
  localparam int DEF_HS = DEF_H_SYNC + DEF_H_BACK + DEF_H_LEFT;
  localparam int DEF_HE = DEF_HS + DEF_H_VALID;
  localparam int DEF_VS = DEF_V_SYNC + DEF_V_BACK + DEF_V_TOP;
  localparam int DEF_VE = DEF_VS + DEF_V_VALID;

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t RED     = 16'hF800;
  localparam rgb565_t GREEN   = 16'h07E0;
  localparam rgb565_t BLUE    = 16'h001F;
  localparam rgb565_t BLACK   = 16'h0000;
  localparam rgb565_t WHITE   = 16'hFFFF;
  localparam rgb565_t GRAY    = 16'h8410;
  localparam rgb565_t YELLOW  = 16'hFFE0;
  localparam rgb565_t CYAN    = 16'h07FF;
  localparam rgb565_t MAGENTA = 16'hF81F;

endpackage

// File: rtl/vga_wrap_cnt.sv
// Enabled up-counter that returns to zero after reaching a terminal value;
// wrap_o flags the enabled clock on which that return happens.
module vga_wrap_cnt #(
  parameter int WIDTH = 10
) (
  input  logic             vga_clk,
  input  logic             sys_rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] term_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign wrap_o = en_i && (cnt_q == term_i);

  always_comb begin
    cnt_d = cnt_q;
    if (wrap_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: sync/active decodes, one-cycle-early pixel
// request coordinates, and gating of the returned pixel onto rgb.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int H_LEFT   = DEF_H_LEFT,
  parameter int H_VALID  = DEF_H_VALID,
  parameter int H_RIGHT  = DEF_H_RIGHT,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int V_TOP    = DEF_V_TOP,
  parameter int V_VALID  = DEF_V_VALID,
  parameter int V_BOTTOM = DEF_V_BOTTOM,
  parameter int V_FRONT  = DEF_V_FRONT
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic        rgb_valid,
  output logic [15:0] rgb,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
  localparam int HS = H_SYNC + H_BACK + H_LEFT;
  localparam int HE = HS + H_VALID;
  localparam int VS = V_SYNC + V_BACK + V_TOP;
  localparam int VE = VS + V_VALID;

  logic [9:0] cnt_h, cnt_v;
  logic       h_wrap, v_wrap;
  logic       h_active, v_active, pix_req;
  logic       frame_start_q, frame_start_d;

  vga_wrap_cnt #(.WIDTH(10)) u_cnt_h (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .en_i      (1'b1),
    .term_i    (10'(H_TOTAL - 1)),
    .cnt_o     (cnt_h),
    .wrap_o    (h_wrap)
  );

  vga_wrap_cnt #(.WIDTH(10)) u_cnt_v (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .en_i      (h_wrap),
    .term_i    (10'(V_TOTAL - 1)),
    .cnt_o     (cnt_v),
    .wrap_o    (v_wrap)
  );

  // The vertical wrap fires on the last clock of a frame, so registering it
  // lines the pulse up with the clock where both counters read zero.
  assign frame_start_d = v_wrap;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync    = cnt_h < 10'(H_SYNC);
  assign vsync    = cnt_v < 10'(V_SYNC);
  assign h_active = (cnt_h >= 10'(HS)) && (cnt_h < 10'(HE));
  assign v_active = (cnt_v >= 10'(VS)) && (cnt_v < 10'(VE));

  assign rgb_valid = h_active && v_active;

  // Requests lead the active window by one clock to cover a registered source.
  assign pix_req = (cnt_h >= 10'(HS - 1)) && (cnt_h < 10'(HE - 1)) && v_active;
  assign pix_x   = pix_req ? cnt_h - 10'(HS - 1) : 10'h3FF;
  assign pix_y   = pix_req ? cnt_v - 10'(VS)     : 10'h3FF;

  assign rgb         = rgb_valid ? pix_data : 16'h0000;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a default 640x480 instance for line-level timing
// and a shrunken-timing instance for whole-frame, pixel-path and reset scenarios.
module tb_vga_timing_ctrl;
  import vga_timing_pkg::*;

  localparam int S_H_SYNC = 4, S_H_BACK = 3, S_H_LEFT = 1, S_H_VALID = 16, S_H_RIGHT = 2, S_H_FRONT = 2;
  localparam int S_V_SYNC = 2, S_V_BACK = 2, S_V_TOP = 1, S_V_VALID = 6, S_V_BOTTOM = 1, S_V_FRONT = 2;
  localparam int S_HTOT = 28, S_HS = 8, S_HE = 24;
  localparam int S_VTOT = 14, S_VS = 5, S_VE = 11;
  localparam int S_FRAME = 392;
  localparam int D_HTOT = 800, D_HS = 144, D_HE = 784;
  localparam int D_VTOT = 525, D_VS = 35, D_VE = 515;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       valid;
    logic       fs;
  } exp_t;

  localparam exp_t RESET_EXP = '{x: 10'h3FF, y: 10'h3FF, hs: 1'b1, vs: 1'b1, valid: 1'b0, fs: 1'b0};

  logic        vga_clk = 1'b0;
  logic        rstnDef, rstnSml;
  logic [15:0] pixDataDef, pixDataSml;
  logic [9:0]  pixXDef, pixYDef, pixXSml, pixYSml;
  logic        hsDef, vsDef, validDef, fsDef, hsSml, vsSml, validSml, fsSml;
  logic [15:0] rgbDef, rgbSml;

  int tDef, tSml, modeDef, modeSml;
  int checks = 0;
  int errors = 0;

  always #5 vga_clk = ~vga_clk;

  vga_timing_ctrl uDef (
    .vga_clk(vga_clk), .sys_rst_n(rstnDef), .pix_data(pixDataDef),
    .pix_x(pixXDef), .pix_y(pixYDef), .hsync(hsDef), .vsync(vsDef),
    .rgb_valid(validDef), .rgb(rgbDef), .frame_start(fsDef)
  );

  vga_timing_ctrl #(
    .H_SYNC(S_H_SYNC), .H_BACK(S_H_BACK), .H_LEFT(S_H_LEFT), .H_VALID(S_H_VALID),
    .H_RIGHT(S_H_RIGHT), .H_FRONT(S_H_FRONT), .V_SYNC(S_V_SYNC), .V_BACK(S_V_BACK),
    .V_TOP(S_V_TOP), .V_VALID(S_V_VALID), .V_BOTTOM(S_V_BOTTOM), .V_FRONT(S_V_FRONT)
  ) uSml (
    .vga_clk(vga_clk), .sys_rst_n(rstnSml), .pix_data(pixDataSml),
    .pix_x(pixXSml), .pix_y(pixYSml), .hsync(hsSml), .vsync(vsSml),
    .rgb_valid(validSml), .rgb(rgbSml), .frame_start(fsSml)
  );

  // Reference raster: position follows from clocks elapsed since reset release;
  // a request at t is exactly the active window at t+1.
  function automatic exp_t model(int t, int hSync, int hs, int he, int hTot,
                                 int vSync, int vs, int ve, int vTot);
    exp_t e;
    int h, line, hn, ln;
    bit req;
    h    = t % hTot;
    line = (t / hTot) % vTot;
    hn   = (t + 1) % hTot;
    ln   = ((t + 1) / hTot) % vTot;
    req  = (hn >= hs) && (hn < he) && (ln >= vs) && (ln < ve);
    e.hs    = (h < hSync);
    e.vs    = (line < vSync);
    e.valid = (h >= hs) && (h < he) && (line >= vs) && (line < ve);
    e.x     = req ? 10'(hn - hs) : 10'h3FF;
    e.y     = req ? 10'(ln - vs) : 10'h3FF;
    e.fs    = (t >= hTot * vTot) && (t % (hTot * vTot) == 0);
    return e;
  endfunction

  function automatic exp_t modelDef(int t);
    return model(t, 96, D_HS, D_HE, D_HTOT, 2, D_VS, D_VE, D_VTOT);
  endfunction

  function automatic exp_t modelSml(int t);
    return model(t, S_H_SYNC, S_HS, S_HE, S_HTOT, S_V_SYNC, S_VS, S_VE, S_VTOT);
  endfunction

  function automatic logic [15:0] barRef(int px, int hValid);
    case ((px * 8) / hValid)
      0:       return RED;
      1:       return GREEN;
      2:       return BLUE;
      3:       return WHITE;
      4:       return YELLOW;
      5:       return CYAN;
      6:       return MAGENTA;
      default: return GRAY;
    endcase
  endfunction

  // Pixel sources: 0 random, 1 echo pix_x, 2 colour bars, 3 forced all-ones
  function automatic logic [15:0] source(int mode, logic [9:0] x, int hValid);
    case (mode)
      1:       return {6'b0, x};
      2:       return (x == 10'h3FF) ? 16'($urandom) : barRef(int'(x), hValid);
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // One pixel clock: latch this cycle's requests, advance, answer a registered
  // source just after the edge, and return at the following falling edge.
  task automatic tick();
    logic [9:0] reqDef, reqSml;
    reqDef = pixXDef;
    reqSml = pixXSml;
    @(posedge vga_clk);
    if (rstnDef) tDef++;
    if (rstnSml) tSml++;
    #1;
    pixDataDef = source(modeDef, reqDef, DEF_H_VALID);
    pixDataSml = source(modeSml, reqSml, S_H_VALID);
    @(negedge vga_clk);
  endtask

  task automatic waitFrameStartSml();
    for (int i = 0; i <= S_FRAME && (tSml % S_FRAME) != 0; i++) tick();
    checks++;
    if ((tSml % S_FRAME) != 0) begin
      errors++;
      $display("[TB] FAIL frame_align: t %0d, required multiple of %0d", tSml, S_FRAME);
    end
  endtask

  task automatic test_reset();
    exp_t a;
    modeDef = 0; modeSml = 0;
    rstnDef = 1'b0; rstnSml = 1'b0;
    pixDataDef = 16'hFFFF; pixDataSml = 16'hFFFF;
    tDef = 0; tSml = 0;
    @(negedge vga_clk);
    for (int i = 0; i < 10; i++) begin
      tick();
      a = {pixXDef, pixYDef, hsDef, vsDef, validDef, fsDef};
      checks++;
      if (a !== RESET_EXP || rgbDef !== 16'h0000) begin
        errors++;
        $display("[TB] FAIL reset_def: got %h rgb %h, required %h rgb 0000", a, rgbDef, RESET_EXP);
      end
      a = {pixXSml, pixYSml, hsSml, vsSml, validSml, fsSml};
      checks++;
      if (a !== RESET_EXP || rgbSml !== 16'h0000) begin
        errors++;
        $display("[TB] FAIL reset_sml: got %h rgb %h, required %h rgb 0000", a, rgbSml, RESET_EXP);
      end
    end
    rstnDef = 1'b1; rstnSml = 1'b1;
    tDef = 0; tSml = 0;
  endtask

  task automatic test_hline();
    exp_t e;
    int fall0 = -1, fall1 = -1, highCnt = 0;
    logic prevHs = 1'b1;
    modeDef = 1; modeSml = 1;
    for (int i = 0; i < 2 * D_HTOT; i++) begin
      e = modelDef(tDef);
      checks++;
      if (hsDef !== e.hs || vsDef !== e.vs) begin
        errors++;
        $display("[TB] FAIL hline_sync t=%0d: got hs %b vs %b, required hs %b vs %b", tDef, hsDef, vsDef, e.hs, e.vs);
      end
      if (tDef < D_HTOT && hsDef === 1'b1) highCnt++;
      if (prevHs === 1'b1 && hsDef === 1'b0) begin
        if (fall0 < 0) fall0 = tDef;
        else if (fall1 < 0) fall1 = tDef;
      end
      prevHs = hsDef;
      tick();
    end
    checks++;
    if (highCnt !== 96) begin
      errors++;
      $display("[TB] FAIL hsync_width: got %0d, required 96", highCnt);
    end
    checks++;
    if (fall0 !== 96 || fall1 - fall0 !== 800) begin
      errors++;
      $display("[TB] FAIL hsync_period: falls at %0d,%0d, required 96,896", fall0, fall1);
    end
  endtask

  task automatic test_request_window();
    int target;
    logic [15:0] expRgb;
    target = 35 * 800 + 143;
    for (int i = 0; i < 40000 && tDef < target; i++) tick();
    checks++;
    if (tDef !== target) begin
      errors++;
      $display("[TB] FAIL window_reach: got t %0d, required %0d", tDef, target);
    end
    for (int h = 143; h < 800; h++) begin
      if (h == 143) begin
        checks++;
        if (pixXDef !== 10'd0 || pixYDef !== 10'd0 || validDef !== 1'b0) begin
          errors++;
          $display("[TB] FAIL first_req: got x %h y %h valid %b, required 000 000 0", pixXDef, pixYDef, validDef);
        end
      end
      if (h == 144) begin
        checks++;
        if (validDef !== 1'b1) begin
          errors++;
          $display("[TB] FAIL first_valid: got %b, required 1", validDef);
        end
      end
      if (h == 782) begin
        checks++;
        if (pixXDef !== 10'd639) begin
          errors++;
          $display("[TB] FAIL last_req: got %0d, required 639", pixXDef);
        end
      end
      if (h == 783) begin
        checks++;
        if (pixXDef !== 10'h3FF || validDef !== 1'b1) begin
          errors++;
          $display("[TB] FAIL line_wrap: got x %h valid %b, required 3ff 1", pixXDef, validDef);
        end
      end
      if (h == 784) begin
        checks++;
        if (validDef !== 1'b0) begin
          errors++;
          $display("[TB] FAIL valid_end: got %b, required 0", validDef);
        end
      end
      expRgb = (h >= 144 && h < 784) ? 16'(h - 144) : 16'h0000;
      checks++;
      if (rgbDef !== expRgb) begin
        errors++;
        $display("[TB] FAIL line35_rgb h=%0d: got %h, required %h", h, rgbDef, expRgb);
      end
      tick();
    end
  endtask

  task automatic test_pixel_path();
    int h, line, nextLine;
    logic expValid;
    logic [15:0] expRgb;
    modeSml = 1;
    waitFrameStartSml();
    for (int c = 0; c < S_FRAME; c++) begin
      h = tSml % S_HTOT;
      line = (tSml / S_HTOT) % S_VTOT;
      expValid = (h >= S_HS) && (h < S_HE) && (line >= S_VS) && (line < S_VE);
      expRgb = expValid ? 16'(h - S_HS) : 16'h0000;
      checks++;
      if (validSml !== expValid || rgbSml !== expRgb) begin
        errors++;
        $display("[TB] FAIL pixel_path line=%0d h=%0d: got valid %b rgb %h, required %b %h",
                 line, h, validSml, rgbSml, expValid, expRgb);
      end
      nextLine = ((tSml + 1) / S_HTOT) % S_VTOT;
      modeSml = (nextLine == S_VE) ? 3 : 1;
      tick();
    end
    modeSml = 1;
  endtask

  task automatic test_frame();
    exp_t e, a;
    int lastFs = -1, pulses = 0;
    logic [15:0] expRgb;
    modeSml = 0;
    for (int c = 0; c < 2 * S_FRAME; c++) begin
      e = modelSml(tSml);
      a = {pixXSml, pixYSml, hsSml, vsSml, validSml, fsSml};
      checks++;
      if (a !== e) begin
        errors++;
        $display("[TB] FAIL frame_timing t=%0d: got %h, required %h", tSml, a, e);
      end
      expRgb = e.valid ? pixDataSml : 16'h0000;
      checks++;
      if (rgbSml !== expRgb) begin
        errors++;
        $display("[TB] FAIL frame_rgb t=%0d: got %h, required %h", tSml, rgbSml, expRgb);
      end
      if (fsSml === 1'b1) begin
        pulses++;
        if (lastFs >= 0) begin
          checks++;
          if (tSml - lastFs !== S_FRAME) begin
            errors++;
            $display("[TB] FAIL frame_period: got %0d, required %0d", tSml - lastFs, S_FRAME);
          end
        end
        lastFs = tSml;
      end
      tick();
    end
    checks++;
    if (pulses !== 2) begin
      errors++;
      $display("[TB] FAIL frame_pulses: got %0d, required 2", pulses);
    end
  endtask

  task automatic test_colour_bar();
    int h, line;
    logic expValid;
    logic [15:0] expRgb;
    modeSml = 2;
    waitFrameStartSml();
    for (int c = 0; c < S_FRAME; c++) begin
      h = tSml % S_HTOT;
      line = (tSml / S_HTOT) % S_VTOT;
      expValid = (h >= S_HS) && (h < S_HE) && (line >= S_VS) && (line < S_VE);
      if (expValid && h == S_HS) begin
        checks++;
        if (rgbSml !== 16'hF800) begin
          errors++;
          $display("[TB] FAIL bar_first line=%0d: got %h, required f800", line, rgbSml);
        end
      end
      expRgb = expValid ? barRef(h - S_HS, S_H_VALID) : 16'h0000;
      checks++;
      if (rgbSml !== expRgb) begin
        errors++;
        $display("[TB] FAIL bar_rgb line=%0d h=%0d: got %h, required %h", line, h, rgbSml, expRgb);
      end
      tick();
    end
  endtask

  task automatic test_midframe_reset();
    exp_t a;
    int line, hh, target;
    line = $urandom_range(S_VE - 1, S_VS);
    hh = $urandom_range(S_HTOT - 2, 1);
    target = line * S_HTOT + hh;
    modeSml = 0;
    for (int i = 0; i <= S_FRAME && (tSml % S_FRAME) != target; i++) tick();
    checks++;
    if ((tSml % S_FRAME) != target) begin
      errors++;
      $display("[TB] FAIL midreset_reach: got %0d, required %0d", tSml % S_FRAME, target);
    end
    #2;
    rstnSml = 1'b0;
    tSml = 0;
    #1;
    a = {pixXSml, pixYSml, hsSml, vsSml, validSml, fsSml};
    checks++;
    if (a !== RESET_EXP || rgbSml !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL midreset_async: got %h rgb %h, required %h rgb 0000", a, rgbSml, RESET_EXP);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      a = {pixXSml, pixYSml, hsSml, vsSml, validSml, fsSml};
      checks++;
      if (a !== RESET_EXP || rgbSml !== 16'h0000) begin
        errors++;
        $display("[TB] FAIL midreset_hold: got %h rgb %h, required %h rgb 0000", a, rgbSml, RESET_EXP);
      end
    end
    rstnSml = 1'b1;
    tSml = 0;
    for (int i = 0; i < 2 * S_FRAME && !(pixXSml === 10'd0 && pixYSml === 10'd0); i++) tick();
    checks++;
    if (tSml !== S_VS * S_HTOT + S_HS - 1) begin
      errors++;
      $display("[TB] FAIL midreset_first_req: got %0d clocks, required %0d", tSml, S_VS * S_HTOT + S_HS - 1);
    end
  endtask

  initial begin
    test_reset();
    test_hline();
    test_request_window();
    test_pixel_path();
    test_frame();
    test_colour_bar();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
